mem_responder_sram: RTL and testbench
=====================================

# mem_responder_sram

Memory-side responder for the core memory interface. It accepts `mem_req` transactions from an instruction or data port, inserts fixed or pseudo-random wait states before asserting `mem_gnt`, and services reads and byte-strobed writes against an internal word array. It returns `mem_rdata`/`mem_err` one cycle after the handshake. It sits below the core in the verification and FPGA top levels, so the core can be exercised against back-pressure and bus errors.

## Interface
- `MEM_ADDR_W`, 64: address width.
- `MEM_DATA_W`, 64: data width; strobe width is `MEM_DATA_W/8`.
- `DEPTH`, 1024: words in the array.
- `BASE_ADDR`, 64'h0: byte address of word 0.
- `STALL_RAND`, 0: 1 selects LFSR-drawn wait states; 0 selects fixed wait states.
- `STALL_FIXED`, 0: wait cycles when `STALL_RAND`=0.
- `STALL_MAX`, 3: maximum wait cycles when `STALL_RAND`=1.
- `LFSR_SEED`, 16'hACE1: LFSR reset value; must be non-zero.
- `g_clk`, in, 1: clock.
- `g_resetn`, in, 1: reset; synchronous, active-low.
- `mem_req`, in, 1: request valid.
- `mem_addr`, in, `MEM_ADDR_W`: byte address; bits [2:0] are ignored.
- `mem_wen`, in, 1: 1 = write.
- `mem_strb`, in, `MEM_DATA_W/8`: byte write enables.
- `mem_wdata`, in, `MEM_DATA_W`: write data.
- `mem_gnt`, out, 1: request accepted this cycle.
- `mem_err`, out, 1: error response; valid the cycle after the handshake.
- `mem_rdata`, out, `MEM_DATA_W`: read data; valid the cycle after the handshake.

## Operation
- Handshake: a transaction completes on a rising edge where `mem_req && mem_gnt`. The requester holds `mem_req`/`mem_addr`/`mem_wen`/`mem_strb`/`mem_wdata` stable from assertion until the handshake.
- FSM states: `IDLE`, `STALL`.
- `IDLE` with `mem_req`:
  - Draw `w` = `STALL_FIXED`, or `lfsr % (STALL_MAX+1)` when `STALL_RAND`=1.
  - If `w`=0: `mem_gnt`=1 combinationally in the same cycle; stay in `IDLE`.
  - Otherwise: go to `STALL` with `cnt`=`w`-1.
- `STALL`:
  - `mem_gnt` = `mem_req && cnt==0`.
  - `cnt` decrements each cycle while non-zero.
  - On handshake, return to `IDLE`.
  - If `mem_req` drops (protocol violation), return to `IDLE` with no response.
- Word index: `(mem_addr - BASE_ADDR) >> 3`. An address outside `[BASE_ADDR, BASE_ADDR + DEPTH*8)` is an error.
- Write handshake, in range: for each byte `i` with `strb[i]`=1, `array[idx].byte[i]` ← `wdata.byte[i]` at the handshake edge. Next cycle: `mem_err`=0, `mem_rdata`=0.
- Read handshake, in range: next cycle `mem_rdata`=`array[idx]` (the post-write value if a write to the same word handshook the previous cycle), `mem_err`=0.
- Out-of-range handshake: the array is not modified. Next cycle: `mem_err`=1, `mem_rdata`=0.
- Outside the response cycle, `mem_err`=0 and `mem_rdata`=0.
- The LFSR (16-bit Galois, taps 16,14,13,11) advances every cycle out of reset.
- Array contents are zero at time 0 and are not affected by `g_resetn`.

## Timing
- Reset values: `mem_gnt`=0, `mem_err`=0, `mem_rdata`=0, state `IDLE`, `cnt`=0, LFSR=`LFSR_SEED`.
- Response latency: exactly 1 cycle after the handshake edge, valid for 1 cycle.
- Throughput: back-to-back handshakes in consecutive cycles when `w`=0. A new request is granted in the same cycle that the previous response is driven.
- Grant latency: `w` cycles after `mem_req` first rises.
- Reset mid-`STALL` or mid-response: state returns to `IDLE`, any pending response is dropped, and outputs are 0 the next cycle.
- Simultaneous events: a write and a response from the previous read in the same cycle are independent. A handshake does not change `mem_rdata` until the following cycle.
- `mem_gnt` depends combinationally on `mem_req`, state and `cnt` only, never on `mem_addr`.

## Structure
- Shared package `mem_if_pkg`: `MEM_ADDR_W` and `MEM_DATA_W` defaults, the LFSR taps constant, and the FSM state enum `mem_rsp_state_t`.
- One sub-module, `mem_stall_lfsr`: 16-bit Galois LFSR with seed parameter, advancing every cycle, output `lfsr[15:0]`.
- Array, FSM, counter and response register live in `mem_responder_sram`.

## Test plan
- `STALL_FIXED`=0: write `0x1122334455667788` to `0x10` with strb `0xFF`, then read `0x10` -> `gnt` in the same cycle each time; next-cycle `rdata`=`0x1122334455667788`, `err`=0.
- Partial strobe: write `0xFFFFFFFFFFFFFFFF` strb `0x0F` to a zeroed word, then read it -> `rdata`=`0x00000000FFFFFFFF`.
- `STALL_FIXED`=2: hold a read request -> `gnt` asserts exactly 2 cycles after `req`; inputs checked stable throughout; response follows 1 cycle after the handshake.
- `BASE_ADDR`=0, `DEPTH`=1024: read `0x2000` -> `err`=1, `rdata`=0 next cycle. Write `0x2000`, then re-read word 0 -> array unchanged.
- `STALL_RAND`=1, `STALL_MAX`=3: 1000 random read/write requests against a scoreboard -> every wait is ≤3 cycles, all data matches, and at least one wait of each length 0..3 is covered.
- Deassert `g_resetn` while in `STALL` with `cnt`=1 -> next cycle `gnt`/`err`/`rdata`=0, state `IDLE`, no response emitted after reset is released.

Source files
------------

// File: rtl/mem_if_pkg.sv
// Shared definitions for the core memory interface: default widths, the
// wait-state LFSR polynomial and the responder FSM states.
package mem_if_pkg;

    localparam int MEM_ADDR_W_DEF = 64;
    localparam int MEM_DATA_W_DEF = 64;

    // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } mem_rsp_state_t;

endpackage

// File: rtl/mem_stall_lfsr.sv
// Free-running 16-bit Galois LFSR that supplies pseudo-random wait-state draws.
module mem_stall_lfsr
    import mem_if_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    output logic [15:0] lfsr
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) lfsr_q <= SEED;
        else           lfsr_q <= lfsr_d;
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/mem_responder_sram.sv
// Memory-side responder: inserts fixed or LFSR-drawn wait states before grant,
// services byte-strobed writes and reads, and registers a one-cycle response.
module mem_responder_sram
    import mem_if_pkg::*;
#(
    parameter int                    MEM_ADDR_W  = MEM_ADDR_W_DEF,
    parameter int                    MEM_DATA_W  = MEM_DATA_W_DEF,
    parameter int                    DEPTH       = 1024,
    parameter logic [MEM_ADDR_W-1:0] BASE_ADDR   = '0,
    parameter bit                    STALL_RAND  = 1'b0,
    parameter int                    STALL_FIXED = 0,
    parameter int                    STALL_MAX   = 3,
    parameter logic [15:0]           LFSR_SEED   = 16'hACE1
) (
    input  logic                    g_clk,
    input  logic                    g_resetn,
    input  logic                    mem_req,
    input  logic [MEM_ADDR_W-1:0]   mem_addr,
    input  logic                    mem_wen,
    input  logic [MEM_DATA_W/8-1:0] mem_strb,
    input  logic [MEM_DATA_W-1:0]   mem_wdata,
    output logic                    mem_gnt,
    output logic                    mem_err,
    output logic [MEM_DATA_W-1:0]   mem_rdata
);

    localparam int STRB_W = MEM_DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [MEM_ADDR_W-1:0] SPAN      = MEM_ADDR_W'(DEPTH) << OFF_W;
    localparam logic [15:0]           STALL_MOD = 16'(STALL_MAX + 1);

    mem_rsp_state_t          state_q, state_d;
    logic [15:0]             cnt_q, cnt_d;
    logic                    rsp_err_q, rsp_err_d;
    logic [MEM_DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [MEM_DATA_W-1:0]   mem_q [DEPTH] = '{default: '0};

    logic [15:0]             lfsr;
    logic [15:0]             wait_draw;
    logic                    gnt_raw;
    logic                    hs;
    logic [MEM_ADDR_W-1:0]   off;
    logic                    in_range;
    logic [IDX_W-1:0]        idx;

    mem_stall_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .lfsr     (lfsr)
    );

    // Addresses below BASE_ADDR wrap to a huge offset, so one compare covers both ends.
    assign off      = mem_addr - BASE_ADDR;
    assign in_range = off < SPAN;
    assign idx      = off[OFF_W +: IDX_W];

    assign wait_draw = STALL_RAND ? (lfsr % STALL_MOD) : 16'(STALL_FIXED);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_raw = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_req) begin
                    if (wait_draw == 16'd0) begin
                        gnt_raw = 1'b1;
                    end else begin
                        state_d = STALL;
                        cnt_d   = wait_draw - 16'd1;
                    end
                end
            end
            STALL: begin
                gnt_raw = mem_req && (cnt_q == 16'd0);
                if (cnt_q != 16'd0) cnt_d = cnt_q - 16'd1;
                // A dropped request abandons the stall without a response.
                if (!mem_req || gnt_raw) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // No handshake can complete while reset is held.
    assign mem_gnt = gnt_raw && g_resetn;
    assign hs      = mem_req && mem_gnt;

    always_comb begin
        rsp_err_d   = hs && !in_range;
        rsp_rdata_d = '0;
        if (hs && in_range && !mem_wen) rsp_rdata_d = mem_q[idx];
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Array contents survive reset.
    always_ff @(posedge g_clk) begin
        if (hs && in_range && mem_wen) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (mem_strb[i]) mem_q[idx][i*8 +: 8] <= mem_wdata[i*8 +: 8];
            end
        end
    end

    assign mem_err   = rsp_err_q;
    assign mem_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_mem_responder_sram.sv
// Directed and scoreboarded checks of mem_responder_sram in three wait-state
// configurations: no stall, fixed 2-cycle stall, and LFSR-drawn stalls.
module tb_mem_responder_sram;

    logic        g_clk = 1'b0;
    logic        g_resetn;
    logic [2:0]  req, wen, gnt, err;
    logic [63:0] addr  [3];
    logic [7:0]  strb  [3];
    logic [63:0] wdata [3];
    logic [63:0] rdata [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 g_clk = ~g_clk;

    mem_responder_sram #(.STALL_FIXED(0)) dut0 (
        .g_clk(g_clk), .g_resetn(g_resetn), .mem_req(req[0]), .mem_addr(addr[0]),
        .mem_wen(wen[0]), .mem_strb(strb[0]), .mem_wdata(wdata[0]),
        .mem_gnt(gnt[0]), .mem_err(err[0]), .mem_rdata(rdata[0]));

    mem_responder_sram #(.STALL_FIXED(2)) dut2 (
        .g_clk(g_clk), .g_resetn(g_resetn), .mem_req(req[1]), .mem_addr(addr[1]),
        .mem_wen(wen[1]), .mem_strb(strb[1]), .mem_wdata(wdata[1]),
        .mem_gnt(gnt[1]), .mem_err(err[1]), .mem_rdata(rdata[1]));

    mem_responder_sram #(.STALL_RAND(1'b1), .STALL_MAX(3)) dutr (
        .g_clk(g_clk), .g_resetn(g_resetn), .mem_req(req[2]), .mem_addr(addr[2]),
        .mem_wen(wen[2]), .mem_strb(strb[2]), .mem_wdata(wdata[2]),
        .mem_gnt(gnt[2]), .mem_err(err[2]), .mem_rdata(rdata[2]));

    // One transaction on port d: returns wait cycles before grant and the response.
    task automatic do_xfer(input int d, input logic w, input logic [63:0] a,
                           input logic [7:0] s, input logic [63:0] wd,
                           output int waits, output logic [63:0] rd,
                           output logic er, output bit to);
        @(posedge g_clk); #1;
        req[d] = 1'b1; wen[d] = w; addr[d] = a; strb[d] = s; wdata[d] = wd;
        waits = 0; to = 1'b0;
        @(negedge g_clk);
        while (gnt[d] !== 1'b1) begin
            if (waits >= 20) begin to = 1'b1; break; end
            waits++;
            @(negedge g_clk);
        end
        @(posedge g_clk); #1;
        req[d] = 1'b0;
        @(negedge g_clk);
        rd = rdata[d];
        er = err[d];
    endtask

    task automatic test_reset();
        g_resetn = 1'b0;
        repeat (3) @(posedge g_clk);
        @(negedge g_clk);
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if (gnt[d] !== 1'b0) begin n_fail++; $display("FAIL reset_gnt[%0d] got %b exp 0", d, gnt[d]); end
            n_checks++;
            if (err[d] !== 1'b0) begin n_fail++; $display("FAIL reset_err[%0d] got %b exp 0", d, err[d]); end
            n_checks++;
            if (rdata[d] !== 64'h0) begin n_fail++; $display("FAIL reset_rdata[%0d] got %h exp 0", d, rdata[d]); end
        end
        @(posedge g_clk); #1;
        g_resetn = 1'b1;
    endtask

    task automatic test_basic();
        int w; logic [63:0] rd; logic er; bit to;
        do_xfer(0, 1'b1, 64'h10, 8'hFF, 64'h1122334455667788, w, rd, er, to);
        n_checks++;
        if (to || w != 0) begin n_fail++; $display("FAIL basic_wr_wait got %0d exp 0", w); end
        n_checks++;
        if (er !== 1'b0 || rd !== 64'h0) begin n_fail++; $display("FAIL basic_wr_rsp got err=%b rdata=%h exp err=0 rdata=0", er, rd); end
        do_xfer(0, 1'b0, 64'h10, 8'h00, 64'h0, w, rd, er, to);
        n_checks++;
        if (to || w != 0) begin n_fail++; $display("FAIL basic_rd_wait got %0d exp 0", w); end
        n_checks++;
        if (er !== 1'b0 || rd !== 64'h1122334455667788) begin
            n_fail++; $display("FAIL basic_rd_rsp got err=%b rdata=%h exp err=0 rdata=1122334455667788", er, rd);
        end
        // Low address bits are ignored.
        do_xfer(0, 1'b0, 64'h17, 8'h00, 64'h0, w, rd, er, to);
        n_checks++;
        if (rd !== 64'h1122334455667788) begin n_fail++; $display("FAIL basic_lowbits got %h exp 1122334455667788", rd); end
    endtask

    task automatic test_partial_strobe();
        int w; logic [63:0] rd; logic er; bit to;
        do_xfer(0, 1'b1, 64'h18, 8'h0F, 64'hFFFFFFFFFFFFFFFF, w, rd, er, to);
        do_xfer(0, 1'b0, 64'h18, 8'h00, 64'h0, w, rd, er, to);
        n_checks++;
        if (er !== 1'b0 || rd !== 64'h00000000FFFFFFFF) begin
            n_fail++; $display("FAIL partial_0f got err=%b rdata=%h exp 00000000ffffffff", er, rd);
        end
        do_xfer(0, 1'b1, 64'h20, 8'h81, 64'h0123456789ABCDEF, w, rd, er, to);
        do_xfer(0, 1'b0, 64'h20, 8'h00, 64'h0, w, rd, er, to);
        n_checks++;
        if (rd !== 64'h01000000000000EF) begin n_fail++; $display("FAIL partial_81 got %h exp 01000000000000ef", rd); end
    endtask

    task automatic test_out_of_range();
        int w; logic [63:0] rd; logic er; bit to;
        do_xfer(0, 1'b1, 64'h0, 8'hFF, 64'hA5A5A5A5A5A5A5A5, w, rd, er, to);
        do_xfer(0, 1'b0, 64'h2000, 8'h00, 64'h0, w, rd, er, to);
        n_checks++;
        if (er !== 1'b1 || rd !== 64'h0) begin n_fail++; $display("FAIL oor_rd got err=%b rdata=%h exp err=1 rdata=0", er, rd); end
        do_xfer(0, 1'b1, 64'h2000, 8'hFF, 64'hDEADBEEFDEADBEEF, w, rd, er, to);
        n_checks++;
        if (er !== 1'b1 || rd !== 64'h0) begin n_fail++; $display("FAIL oor_wr got err=%b rdata=%h exp err=1 rdata=0", er, rd); end
        do_xfer(0, 1'b0, 64'h0, 8'h00, 64'h0, w, rd, er, to);
        n_checks++;
        if (er !== 1'b0 || rd !== 64'hA5A5A5A5A5A5A5A5) begin
            n_fail++; $display("FAIL oor_word0 got err=%b rdata=%h exp err=0 rdata=a5a5a5a5a5a5a5a5", er, rd);
        end
        do_xfer(0, 1'b0, 64'h1FF8, 8'h00, 64'h0, w, rd, er, to);
        n_checks++;
        if (er !== 1'b0 || rd !== 64'h0) begin n_fail++; $display("FAIL last_word got err=%b rdata=%h exp err=0 rdata=0", er, rd); end
    endtask

    task automatic test_back_to_back();
        @(posedge g_clk); #1;
        req[0] = 1'b1; wen[0] = 1'b1; addr[0] = 64'h30; strb[0] = 8'hFF; wdata[0] = 64'hCAFEF00D12345678;
        @(negedge g_clk);
        n_checks++;
        if (gnt[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_gnt_wr got %b exp 1", gnt[0]); end
        @(posedge g_clk); #1;
        wen[0] = 1'b0;
        @(negedge g_clk);
        n_checks++;
        if (gnt[0] !== 1'b1 || err[0] !== 1'b0 || rdata[0] !== 64'h0) begin
            n_fail++; $display("FAIL b2b_gnt_rd got gnt=%b err=%b rdata=%h exp gnt=1 err=0 rdata=0", gnt[0], err[0], rdata[0]);
        end
        @(posedge g_clk); #1;
        req[0] = 1'b0;
        @(negedge g_clk);
        n_checks++;
        if (err[0] !== 1'b0 || rdata[0] !== 64'hCAFEF00D12345678) begin
            n_fail++; $display("FAIL b2b_rd_data got err=%b rdata=%h exp err=0 rdata=cafef00d12345678", err[0], rdata[0]);
        end
        @(negedge g_clk);
        n_checks++;
        if (rdata[0] !== 64'h0) begin n_fail++; $display("FAIL b2b_rsp_1cyc got %h exp 0", rdata[0]); end
    endtask

    task automatic test_stall_fixed();
        int w; logic [63:0] rd; logic er; bit to;
        do_xfer(1, 1'b1, 64'h40, 8'hFF, 64'h0F0E0D0C0B0A0908, w, rd, er, to);
        n_checks++;
        if (to || w != 2) begin n_fail++; $display("FAIL stall_wr_wait got %0d exp 2", w); end
        do_xfer(1, 1'b0, 64'h40, 8'h00, 64'h0, w, rd, er, to);
        n_checks++;
        if (to || w != 2) begin n_fail++; $display("FAIL stall_rd_wait got %0d exp 2", w); end
        n_checks++;
        if (er !== 1'b0 || rd !== 64'h0F0E0D0C0B0A0908) begin
            n_fail++; $display("FAIL stall_rd_data got err=%b rdata=%h exp 0f0e0d0c0b0a0908", er, rd);
        end
    endtask

    task automatic test_reset_in_stall();
        int w; logic [63:0] rd; logic er; bit to; bit quiet;
        @(posedge g_clk); #1;
        req[1] = 1'b1; wen[1] = 1'b0; addr[1] = 64'h40; strb[1] = 8'h00;
        @(negedge g_clk);
        n_checks++;
        if (gnt[1] !== 1'b0) begin n_fail++; $display("FAIL rst_stall_early_gnt got %b exp 0", gnt[1]); end
        @(posedge g_clk); #1;
        g_resetn = 1'b0;
        @(posedge g_clk); #1;
        g_resetn = 1'b1;
        req[1] = 1'b0;
        @(negedge g_clk);
        n_checks++;
        if (gnt[1] !== 1'b0 || err[1] !== 1'b0 || rdata[1] !== 64'h0) begin
            n_fail++; $display("FAIL rst_stall_outs got gnt=%b err=%b rdata=%h exp all 0", gnt[1], err[1], rdata[1]);
        end
        quiet = 1'b1;
        repeat (4) begin
            @(negedge g_clk);
            if (err[1] !== 1'b0 || rdata[1] !== 64'h0) quiet = 1'b0;
        end
        n_checks++;
        if (!quiet) begin n_fail++; $display("FAIL rst_stall_no_rsp got response after reset exp none"); end
        do_xfer(1, 1'b0, 64'h40, 8'h00, 64'h0, w, rd, er, to);
        n_checks++;
        if (to || w != 2 || rd !== 64'h0F0E0D0C0B0A0908) begin
            n_fail++; $display("FAIL rst_stall_recover got wait=%0d rdata=%h exp wait=2 rdata=0f0e0d0c0b0a0908", w, rd);
        end
    endtask

    task automatic test_random();
        logic [63:0] model [16];
        int hist [4];
        int w, k;
        logic [63:0] rd, d, a;
        logic er, wr;
        logic [7:0] s;
        bit to;
        for (int i = 0; i < 16; i++) model[i] = 64'h0;
        for (int i = 0; i < 4; i++) hist[i] = 0;
        for (int n = 0; n < 1000; n++) begin
            k  = $urandom_range(0, 15);
            a  = (64'(k) << 3) | 64'($urandom_range(0, 7));
            wr = 1'($urandom_range(0, 1));
            s  = 8'($urandom);
            d  = {$urandom, $urandom};
            do_xfer(2, wr, a, s, d, w, rd, er, to);
            n_checks++;
            if (to || w > 3) begin n_fail++; $display("FAIL rand_wait[%0d] got %0d exp <=3", n, w); end
            else hist[w]++;
            if (wr) begin
                for (int b = 0; b < 8; b++) if (s[b]) model[k][b*8 +: 8] = d[b*8 +: 8];
                n_checks++;
                if (er !== 1'b0 || rd !== 64'h0) begin n_fail++; $display("FAIL rand_wr[%0d] got err=%b rdata=%h exp 0/0", n, er, rd); end
            end else begin
                n_checks++;
                if (er !== 1'b0 || rd !== model[k]) begin
                    n_fail++; $display("FAIL rand_rd[%0d] word %0d got err=%b rdata=%h exp err=0 rdata=%h", n, k, er, rd, model[k]);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (hist[i] == 0) begin n_fail++; $display("FAIL rand_cover_wait%0d got 0 hits exp >0", i); end
        end
    endtask

    initial begin
        req = '0; wen = '0;
        for (int d = 0; d < 3; d++) begin
            addr[d] = '0; strb[d] = '0; wdata[d] = '0;
        end
        test_reset();
        test_basic();
        test_partial_strobe();
        test_out_of_range();
        test_back_to_back();
        test_stall_fixed();
        test_reset_in_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
